// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the PC source mux, the hazard FSM states and the stall counter.
package pipe_ctrl_pkg;

    localparam int REG_W  = 5;
    localparam int SCNT_W = 3;

    typedef logic [1:0] pc_sel_t;

    localparam pc_sel_t PC_SEQ    = 2'b00;
    localparam pc_sel_t PC_BRANCH = 2'b01;
    localparam pc_sel_t PC_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LD_STALL = 2'b01,
        ST_HOLD     = 2'b10
    } state_t;

    // Remaining stall cycles after the first bubble, which is issued while still in RUN.
    function automatic logic [SCNT_W-1:0] stall_reload(input int cyc);
        return SCNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status into the controller, PC/pipeline-register controls out.
interface pipe_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [REG_W-1:0] rs_id;
    logic [REG_W-1:0] rt_id;
    logic             uses_rs_id;
    logic             uses_rt_id;
    logic             memread_ex;
    logic [REG_W-1:0] rt_ex;
    logic             saltocond_mem;
    logic             ozero_mem;
    logic             saltoincond_id;
    logic             ext_stall;

    logic             pc_write;
    logic             ifid_write;
    pc_sel_t          pc_sel;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;

    // The controller side drives the control outputs.
    modport master (
        input  rs_id, rt_id, uses_rs_id, uses_rt_id, memread_ex, rt_ex,
               saltocond_mem, ozero_mem, saltoincond_id, ext_stall,
        output pc_write, ifid_write, pc_sel, ifid_flush, idex_flush, exmem_flush
    );

    modport slave (
        output rs_id, rt_id, uses_rs_id, uses_rt_id, memread_ex, rt_ex,
               saltocond_mem, ozero_mem, saltoincond_id, ext_stall,
        input  pc_write, ifid_write, pc_sel, ifid_flush, idex_flush, exmem_flush
    );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the load in EX and the source registers of the ID instruction.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             memread_ex,
    input  logic [REG_W-1:0] rt_ex,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             uses_rs_id,
    input  logic             uses_rt_id,
    output logic             hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = uses_rs_id && (rt_ex == rs_id);
    assign rt_match = uses_rt_id && (rt_ex == rt_id);

    // Register 0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign hazard = memread_ex && (rt_ex != '0) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/redirect controller: decides PC advance/hold/redirect and pipeline flushes each cycle,
// and keeps saturating stall and flush event counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYC = 1,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    pipe_hazard_ctrl_if.master bus,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_ONE : v;
    endfunction

    state_t            state;
    state_t            state_nxt;
    state_t            ret_state;
    state_t            ret_nxt;
    state_t            eff_state;
    logic [SCNT_W-1:0] scnt;
    logic [SCNT_W-1:0] scnt_nxt;

    logic    hazard;
    logic    taken;
    logic    pc_write_c;
    logic    ifid_write_c;
    pc_sel_t pc_sel_c;
    logic    ifid_flush_c;
    logic    idex_flush_c;
    logic    exmem_flush_c;
    logic    any_flush;

    load_use_detect u_load_use_detect (
        .memread_ex (bus.memread_ex),
        .rt_ex      (bus.rt_ex),
        .rs_id      (bus.rs_id),
        .rt_id      (bus.rt_id),
        .uses_rs_id (bus.uses_rs_id),
        .uses_rt_id (bus.uses_rt_id),
        .hazard     (hazard)
    );

    assign taken = bus.saltocond_mem && bus.ozero_mem;

    always_comb begin
        state_nxt     = state;
        ret_nxt       = ret_state;
        scnt_nxt      = scnt;
        pc_write_c    = 1'b0;
        ifid_write_c  = 1'b0;
        pc_sel_c      = PC_SEQ;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_flush_c = 1'b0;

        // Leaving HOLD resumes the interrupted state's rules within the same cycle.
        eff_state = state;
        if ((state == ST_HOLD) && !bus.ext_stall) begin
            eff_state = ret_state;
        end

        case (eff_state)
            ST_RUN: begin
                if (bus.ext_stall) begin
                    ret_nxt   = ST_RUN;
                    state_nxt = ST_HOLD;
                end else if (taken) begin
                    pc_sel_c      = PC_BRANCH;
                    pc_write_c    = 1'b1;
                    ifid_write_c  = 1'b1;
                    ifid_flush_c  = 1'b1;
                    idex_flush_c  = 1'b1;
                    exmem_flush_c = 1'b1;
                    state_nxt     = ST_RUN;
                end else if (bus.saltoincond_id) begin
                    pc_sel_c     = PC_JUMP;
                    pc_write_c   = 1'b1;
                    ifid_write_c = 1'b1;
                    ifid_flush_c = 1'b1;
                    state_nxt    = ST_RUN;
                end else if (hazard) begin
                    idex_flush_c = 1'b1;
                    state_nxt    = ST_RUN;
                    if (LOAD_STALL_CYC > 1) begin
                        scnt_nxt  = stall_reload(LOAD_STALL_CYC);
                        state_nxt = ST_LD_STALL;
                    end
                end else begin
                    pc_write_c   = 1'b1;
                    ifid_write_c = 1'b1;
                    state_nxt    = ST_RUN;
                end
            end

            ST_LD_STALL: begin
                if (bus.ext_stall) begin
                    ret_nxt   = ST_LD_STALL;
                    state_nxt = ST_HOLD;
                end else if (taken) begin
                    // The branch is older than the stalled load, so its redirect wins.
                    pc_sel_c      = PC_BRANCH;
                    pc_write_c    = 1'b1;
                    ifid_write_c  = 1'b1;
                    ifid_flush_c  = 1'b1;
                    idex_flush_c  = 1'b1;
                    exmem_flush_c = 1'b1;
                    scnt_nxt      = '0;
                    state_nxt     = ST_RUN;
                end else begin
                    idex_flush_c = 1'b1;
                    scnt_nxt     = scnt - 1'b1;
                    state_nxt    = (scnt == 3'd1) ? ST_RUN : ST_LD_STALL;
                end
            end

            default: begin
                state_nxt = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            ret_state <= ST_RUN;
            scnt      <= '0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            scnt      <= scnt_nxt;
        end
    end

    // Reset forces every control low so the PC stays frozen while reset is held.
    assign bus.pc_write    = pc_write_c    && !reset;
    assign bus.ifid_write  = ifid_write_c  && !reset;
    assign bus.pc_sel      = reset ? PC_SEQ : pc_sel_c;
    assign bus.ifid_flush  = ifid_flush_c  && !reset;
    assign bus.idex_flush  = idex_flush_c  && !reset;
    assign bus.exmem_flush = exmem_flush_c && !reset;

    assign any_flush = ifid_flush_c || idex_flush_c || exmem_flush_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            stall_cycles <= sat_inc(stall_cycles, !pc_write_c);
            flush_events <= sat_inc(flush_events, any_flush);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: instance a (3-cycle load stall, 32-bit counters), instance b (1-cycle stall, 4-bit counters).
module tb_pipe_hazard_ctrl;

    // {pc_write, ifid_write, pc_sel[1:0], ifid_flush, idex_flush, exmem_flush}
    localparam logic [31:0] ZERO  = 32'b000_0000;
    localparam logic [31:0] SEQ   = 32'b110_0000;
    localparam logic [31:0] STALL = 32'b000_0010;
    localparam logic [31:0] BR    = 32'b110_1111;
    localparam logic [31:0] JMP   = 32'b111_0100;

    logic        clk;
    logic        rst_a;
    logic        rst_b;
    logic [31:0] stall_a;
    logic [31:0] flush_a;
    logic [3:0]  stall_b;
    logic [3:0]  flush_b;
    logic [6:0]  ctl_a;
    logic [6:0]  ctl_b;
    int          n_cmp;
    int          n_bad;

    pipe_hazard_ctrl_if a ();
    pipe_hazard_ctrl_if b ();

    pipe_hazard_ctrl #(.LOAD_STALL_CYC(3), .CNT_W(32)) dut_a (
        .clk          (clk),
        .reset        (rst_a),
        .bus          (a),
        .stall_cycles (stall_a),
        .flush_events (flush_a)
    );

    pipe_hazard_ctrl #(.LOAD_STALL_CYC(1), .CNT_W(4)) dut_b (
        .clk          (clk),
        .reset        (rst_b),
        .bus          (b),
        .stall_cycles (stall_b),
        .flush_events (flush_b)
    );

    assign ctl_a = {a.pc_write, a.ifid_write, a.pc_sel, a.ifid_flush, a.idex_flush, a.exmem_flush};
    assign ctl_b = {b.pc_write, b.ifid_write, b.pc_sel, b.ifid_flush, b.idex_flush, b.exmem_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_a();
        a.rs_id = 5'd0; a.rt_id = 5'd0; a.uses_rs_id = 1'b0; a.uses_rt_id = 1'b0;
        a.memread_ex = 1'b0; a.rt_ex = 5'd0; a.saltocond_mem = 1'b0; a.ozero_mem = 1'b0;
        a.saltoincond_id = 1'b0; a.ext_stall = 1'b0;
    endtask

    task automatic clr_b();
        b.rs_id = 5'd0; b.rt_id = 5'd0; b.uses_rs_id = 1'b0; b.uses_rt_id = 1'b0;
        b.memread_ex = 1'b0; b.rt_ex = 5'd0; b.saltocond_mem = 1'b0; b.ozero_mem = 1'b0;
        b.saltoincond_id = 1'b0; b.ext_stall = 1'b0;
    endtask

    task automatic haz_rs_a();
        a.memread_ex = 1'b1; a.rt_ex = 5'd8; a.rs_id = 5'd8; a.uses_rs_id = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        clr_a();
        clr_b();

        #1;
        chk("reset_ctl", 32'(ctl_a), ZERO);
        chk("reset_stall_cnt", stall_a, 32'd0);
        chk("reset_flush_cnt", flush_a, 32'd0);
        @(negedge clk); rst_a = 1'b0;

        // Idle flow and the zero-register filter
        @(negedge clk); clr_a(); #1 chk("idle_seq", 32'(ctl_a), SEQ);
        @(negedge clk); clr_a(); a.memread_ex = 1'b1; a.rt_ex = 5'd0; a.rs_id = 5'd0; a.uses_rs_id = 1'b1;
        #1 chk("r0_no_stall", 32'(ctl_a), SEQ);

        // Three-cycle load-use stall; hazard inputs drop after the first cycle
        @(negedge clk); clr_a(); haz_rs_a(); #1 chk("ld_stall_1", 32'(ctl_a), STALL);
        @(negedge clk); clr_a(); #1 chk("ld_stall_2", 32'(ctl_a), STALL);
        @(negedge clk); clr_a(); #1 chk("ld_stall_3", 32'(ctl_a), STALL);
        @(negedge clk); clr_a(); #1 chk("ld_stall_done", 32'(ctl_a), SEQ);
        chk("ld_stall_cnt", stall_a, 32'd3);
        chk("ld_flush_cnt", flush_a, 32'd3);

        // Taken branch aborts the stall in its second cycle
        @(negedge clk); clr_a(); haz_rs_a(); #1 chk("br_abort_stall", 32'(ctl_a), STALL);
        @(negedge clk); clr_a(); a.saltocond_mem = 1'b1; a.ozero_mem = 1'b1;
        #1 chk("br_abort_redirect", 32'(ctl_a), BR);
        @(negedge clk); clr_a(); a.saltocond_mem = 1'b1; a.ozero_mem = 1'b0;
        #1 chk("br_not_taken", 32'(ctl_a), SEQ);
        chk("br_stall_cnt", stall_a, 32'd4);
        chk("br_flush_cnt", flush_a, 32'd5);

        // Jump beats a simultaneous load-use match
        @(negedge clk); clr_a(); haz_rs_a(); a.saltoincond_id = 1'b1; #1 chk("jmp_vs_ld", 32'(ctl_a), JMP);
        @(negedge clk); clr_a(); #1 chk("jmp_no_stall", 32'(ctl_a), SEQ);
        chk("jmp_stall_cnt", stall_a, 32'd4);
        chk("jmp_flush_cnt", flush_a, 32'd6);

        // Freeze for 4 cycles inside the stall (hazard through the rt field)
        @(negedge clk); clr_a(); a.memread_ex = 1'b1; a.rt_ex = 5'd3; a.rt_id = 5'd3; a.uses_rt_id = 1'b1;
        a.rs_id = 5'd9; a.uses_rs_id = 1'b1;
        #1 chk("frz_stall_1", 32'(ctl_a), STALL);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); clr_a(); a.ext_stall = 1'b1; #1 chk("frz_hold", 32'(ctl_a), ZERO);
        end
        @(negedge clk); clr_a(); #1 chk("frz_stall_2", 32'(ctl_a), STALL);
        @(negedge clk); clr_a(); #1 chk("frz_stall_3", 32'(ctl_a), STALL);
        @(negedge clk); clr_a(); #1 chk("frz_done", 32'(ctl_a), SEQ);
        chk("frz_stall_cnt", stall_a, 32'd11);
        chk("frz_flush_cnt", flush_a, 32'd9);

        // ext_stall outranks a taken branch; the branch applies on release
        @(negedge clk); clr_a(); a.ext_stall = 1'b1; a.saltocond_mem = 1'b1; a.ozero_mem = 1'b1;
        #1 chk("ext_over_br", 32'(ctl_a), ZERO);
        @(negedge clk); clr_a(); a.saltocond_mem = 1'b1; a.ozero_mem = 1'b1;
        #1 chk("hold_release_br", 32'(ctl_a), BR);
        @(negedge clk); clr_a(); #1 chk("hold_release_seq", 32'(ctl_a), SEQ);
        chk("hold_stall_cnt", stall_a, 32'd12);
        chk("hold_flush_cnt", flush_a, 32'd10);

        // Asynchronous reset in the middle of a HOLD that would return to LD_STALL
        @(negedge clk); clr_a(); haz_rs_a(); #1 chk("rst_pre_stall", 32'(ctl_a), STALL);
        @(negedge clk); clr_a(); a.ext_stall = 1'b1; #1 chk("rst_pre_hold", 32'(ctl_a), ZERO);
        @(negedge clk); clr_a(); a.ext_stall = 1'b1; #1 chk("rst_in_hold", 32'(ctl_a), ZERO);
        chk("rst_pre_stall_cnt", stall_a, 32'd14);
        chk("rst_pre_flush_cnt", flush_a, 32'd11);
        #2 rst_a = 1'b1;
        #1 chk("rst_async_ctl", 32'(ctl_a), ZERO);
        chk("rst_async_stall_cnt", stall_a, 32'd0);
        chk("rst_async_flush_cnt", flush_a, 32'd0);
        @(negedge clk); rst_a = 1'b0; clr_a(); #1 chk("rst_resume_run", 32'(ctl_a), SEQ);
        @(negedge clk); clr_a(); #1 chk("rst_resume_run2", 32'(ctl_a), SEQ);
        chk("rst_after_stall_cnt", stall_a, 32'd0);

        // Instance b: single-cycle load stall, then counter saturation at 15
        @(negedge clk); rst_b = 1'b0; clr_b(); #1 chk("b_idle", 32'(ctl_b), SEQ);
        @(negedge clk); clr_b(); b.memread_ex = 1'b1; b.rt_ex = 5'd8; b.rs_id = 5'd8; b.uses_rs_id = 1'b1;
        #1 chk("b_ld_stall", 32'(ctl_b), STALL);
        @(negedge clk); clr_b(); #1 chk("b_ld_done", 32'(ctl_b), SEQ);
        chk("b_stall_cnt", 32'(stall_b), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); clr_b(); b.ext_stall = 1'b1; #1 chk("b_freeze", 32'(ctl_b), ZERO);
            if (i == 10) chk("b_stall_cnt_mid", 32'(stall_b), 32'd11);
        end
        @(negedge clk); clr_b(); #1 chk("b_release", 32'(ctl_b), SEQ);
        chk("b_stall_sat", 32'(stall_b), 32'd15);
        chk("b_flush_cnt", 32'(flush_b), 32'd1);
        @(negedge clk); clr_b(); #1 chk("b_stall_sat_hold", 32'(stall_b), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and redirect controller for the 5-stage segmented processor. It sequences the program counter and the IF/ID, ID/EX and EX/MEM pipeline registers. Each cycle it decides whether the PC advances, holds, or is redirected to a branch or jump target, and which pipeline registers are flushed. It sits beside the PC block: `pc_write` gates the PC register, and `pc_sel` drives the PC source mux.

## Interface
- `LOAD_STALL_CYC`, 1: bubbles inserted per load-use hazard; legal range 1..7.
- `CNT_W`, 32: width of the performance counters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `rs_id`, `rt_id` in 5: source register fields of the instruction in ID.
- `uses_rs_id`, `uses_rt_id` in 1: the ID instruction actually reads rs / rt.
- `memread_ex` in 1: the instruction in EX is a load.
- `rt_ex` in 5: destination of that load.
- `saltocond_mem`, `ozero_mem` in 1: conditional branch and ALU zero flag, both in MEM.
- `saltoincond_id` in 1: unconditional jump decoded in ID.
- `ext_stall` in 1: freeze request from a multicycle unit.
- `pc_write` out 1: PC load enable.
- `ifid_write` out 1: IF/ID load enable.
- `pc_sel` out 2: PC source. 00 = sequential (PC+1), 01 = branch target, 10 = jump target.
- `ifid_flush`, `idex_flush`, `exmem_flush` out 1: insert a bubble in that register.
- `stall_cycles` out CNT_W: count of cycles with `pc_write`=0.
- `flush_events` out CNT_W: count of cycles with any flush asserted.

## Operation
- **Outputs.** All control outputs are combinational decodes of the FSM state and the inputs. Performance counters are registered.
- **FSM states.** `RUN`, `LD_STALL` and `HOLD`. A 3-bit stall counter `scnt` and a `ret_state` register are also kept.
- **Load-use hazard.** Defined as `memread_ex & rt_ex!=0 & ((uses_rs_id & rt_ex==rs_id) | (uses_rt_id & rt_ex==rt_id))`.
- **Priority in `RUN`** (highest first):
  1. `ext_stall`: all outputs 0 and `pc_sel`=00. Set `ret_state`=RUN and go to `HOLD`.
  2. Taken branch (`saltocond_mem & ozero_mem`): `pc_sel`=01, `pc_write`=`ifid_write`=1, and all three flushes = 1. Stay in `RUN`.
  3. `saltoincond_id`: `pc_sel`=10, `pc_write`=`ifid_write`=1, `ifid_flush`=1. Stay in `RUN`. A jump beats a simultaneous load-use match.
  4. Load-use hazard: `pc_write`=`ifid_write`=0, `idex_flush`=1. If `LOAD_STALL_CYC`>1, load `scnt`=LOAD_STALL_CYC-1 and go to `LD_STALL`; otherwise stay in `RUN`.
  5. Otherwise: `pc_sel`=00 and `pc_write`=`ifid_write`=1.
- **`LD_STALL`:**
  - `ext_stall`: freeze as in `RUN`, with `ret_state`=LD_STALL and `scnt` held.
  - Taken branch: the branch is older than the load, so it wins. Apply the full branch redirect and flush, clear `scnt`, and go to `RUN`.
  - Otherwise: `pc_write`=`ifid_write`=0 and `idex_flush`=1. Decrement `scnt`; when `scnt`==1 at the edge, go to `RUN`.
- **`HOLD`:** all outputs 0. While `ext_stall`=1, stay. When `ext_stall`=0, apply the rules of `ret_state` in that same cycle, including its state transition.
- **Counters:** `stall_cycles` increments every non-reset cycle with `pc_write`=0. `flush_events` increments every cycle with any flush=1. Both saturate at all-ones and never wrap.

## Timing
- Control outputs have zero latency: they respond in the same cycle as their inputs. State and counters update on the rising edge of `clk`; counter values are visible one cycle later.
- A load-use hazard costs exactly `LOAD_STALL_CYC` cycles with `pc_write`=0, excluding any `ext_stall` cycles.
- A taken branch costs 3 flushed slots; a jump costs 1.
- **Reset values.** While `reset`=1: state=RUN, `scnt`=0, `ret_state`=RUN, both counters 0. All outputs are 0 (PC frozen, `pc_sel`=00, no flushes).
- **Reset mid-operation.** Reset asserted during `LD_STALL` or `HOLD` aborts it immediately and asynchronously. The first edge after release evaluates in `RUN`.
- **Simultaneous events.** Priority is strictly: `ext_stall` > branch > jump > load-use.

## Structure
- **Shared package** `pipe_ctrl_pkg`: `PC_SEQ`=2'b00, `PC_BRANCH`=2'b01, `PC_JUMP`=2'b10, and the state encodings `ST_RUN`, `ST_LD_STALL`, `ST_HOLD`. The PC mux and the decoder reuse the `pc_sel` encodings.
- **Sub-module** `load_use_detect`: purely combinational register-compare producing the hazard bit. It is instanced once.
- **Top module:** the FSM, `scnt`, `ret_state` and the saturating counters live in `pipe_hazard_ctrl`.

## Test plan
- **Load-use:** `memread_ex`=1, `rt_ex`=8, `rs_id`=8, `uses_rs_id`=1, `LOAD_STALL_CYC`=1 -> one cycle with `pc_write`=0 and `idex_flush`=1, then normal flow; `stall_cycles`=1.
- **Zero-register filter and multi-cycle stall:** the same hazard with `rt_ex`=0 -> no stall. With `LOAD_STALL_CYC`=3 -> exactly 3 stall cycles, then `RUN`.
- **Branch aborts load stall:** `saltocond_mem`=`ozero_mem`=1 during the second cycle of `LD_STALL` (`LOAD_STALL_CYC`=3) -> `pc_sel`=01 and all flushes=1 that cycle, next state `RUN`; `flush_events` increments by 1.
- **Jump vs. load-use:** `saltoincond_id`=1 together with a matching load-use -> `pc_sel`=10, `ifid_flush`=1, `pc_write`=1, no stall.
- **Freeze in stall:** `ext_stall`=1 for 4 cycles inside `LD_STALL` -> all outputs 0 and `scnt` frozen. After release, the remaining stall cycles complete; `stall_cycles` counts both the freeze and the stall cycles.
- **Reset and saturation:** assert `reset` asynchronously in mid-`HOLD` -> outputs 0 immediately and counters 0. With `CNT_W`=4, 20 stall cycles -> `stall_cycles` holds at 15.
